// File: rtl/sp_writer.sv
// Scratchpad writer: streams a row-major matrix of result elements into
// scratchpad sub-addresses row*MAX_DIM+col for one latched target.
// Latency 1 (element accepted -> registered write); elem_valid_i low stalls cleanly.
module sp_writer #(
  parameter int SP_NTARGETS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int BUS_WIDTH   = 64,
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  localparam int LG         = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1,
  localparam int AW         = 2 * LG,
  localparam int TW         = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1,
  localparam int DW         = LG + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [TW-1:0]        target_i,
  input  logic [DW-1:0]        n_rows_i,
  input  logic [DW-1:0]        n_cols_i,
  input  logic                 elem_valid_i,
  input  logic [BUS_WIDTH-1:0] elem_data_i,
  output logic                 elem_ready_o,
  output logic                 sp_we_o,
  output logic [AW-1:0]        sp_addr_o,
  output logic [TW-1:0]        sp_target_o,
  output logic [BUS_WIDTH-1:0] sp_data_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

  // Counters only ever hold 0..MAX_DIM-1.
  localparam int CW = LG;

  state_t               state_q, state_d;
  logic [TW-1:0]        target_q, target_d;
  logic [DW-1:0]        n_rows_q, n_rows_d;
  logic [DW-1:0]        n_cols_q, n_cols_d;
  logic [CW-1:0]        row_q, row_d;
  logic [CW-1:0]        col_q, col_d;
  logic                 sp_we_q, sp_we_d;
  logic [AW-1:0]        sp_addr_q, sp_addr_d;
  logic [TW-1:0]        sp_target_q, sp_target_d;
  logic [BUS_WIDTH-1:0] sp_data_q, sp_data_d;
  logic                 done_q, done_d;

  logic xfer;
  logic last_col;
  logic last_row;

  // Zero encodes a full MAX_DIM extent; oversized requests saturate to MAX_DIM.
  function automatic logic [DW-1:0] norm_dim(input logic [DW-1:0] v);
    if (v == '0 || v > DW'(MAX_DIM)) begin
      return DW'(MAX_DIM);
    end
    return v;
  endfunction

  assign xfer     = (state_q == S_WRITE) && elem_valid_i;
  assign last_col = (DW'(col_q) == n_cols_q - DW'(1));
  assign last_row = (DW'(row_q) == n_rows_q - DW'(1));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave IDLE on start, return once the last element is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_WRITE;
      S_WRITE: if (xfer && last_col && last_row) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: the writer accepts elements exactly while a transfer is open.
  always_comb begin
    elem_ready_o = 1'b0;
    busy_o       = 1'b0;
    if (state_q == S_WRITE) begin
      elem_ready_o = 1'b1;
      busy_o       = 1'b1;
    end
  end

  // Datapath: latch the job at start, then turn each accepted element into one write.
  always_comb begin
    target_d    = target_q;
    n_rows_d    = n_rows_q;
    n_cols_d    = n_cols_q;
    row_d       = row_q;
    col_d       = col_q;
    sp_we_d     = 1'b0;
    sp_addr_d   = sp_addr_q;
    sp_target_d = sp_target_q;
    sp_data_d   = sp_data_q;
    done_d      = 1'b0;

    if (state_q == S_IDLE && start_i) begin
      target_d = target_i;
      n_rows_d = norm_dim(n_rows_i);
      n_cols_d = norm_dim(n_cols_i);
      row_d    = '0;
      col_d    = '0;
    end

    if (xfer) begin
      sp_we_d     = 1'b1;
      sp_addr_d   = AW'(row_q) * AW'(MAX_DIM) + AW'(col_q);
      sp_target_d = target_q;
      sp_data_d   = elem_data_i;
      if (last_col) begin
        col_d = '0;
        row_d = row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      // done_o lines up with the write of the final element.
      done_d = last_col && last_row;
    end
  end

  // Datapath registers; reset clears everything including the held write fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      target_q    <= '0;
      n_rows_q    <= '0;
      n_cols_q    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      sp_we_q     <= 1'b0;
      sp_addr_q   <= '0;
      sp_target_q <= '0;
      sp_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      target_q    <= target_d;
      n_rows_q    <= n_rows_d;
      n_cols_q    <= n_cols_d;
      row_q       <= row_d;
      col_q       <= col_d;
      sp_we_q     <= sp_we_d;
      sp_addr_q   <= sp_addr_d;
      sp_target_q <= sp_target_d;
      sp_data_q   <= sp_data_d;
      done_q      <= done_d;
    end
  end

  assign sp_we_o     = sp_we_q;
  assign sp_addr_o   = sp_addr_q;
  assign sp_target_o = sp_target_q;
  assign sp_data_o   = sp_data_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_sp_writer.sv
// Testbench for sp_writer with default parameters (MAX_DIM=2, AW=2, TW=2, DW=2).
// Expected writes are queued as elements are driven and popped as writes appear.
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_sp_writer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  target_i;
  logic [1:0]  n_rows_i;
  logic [1:0]  n_cols_i;
  logic        elem_valid_i;
  logic [63:0] elem_data_i;
  logic        elem_ready_o;
  logic        sp_we_o;
  logic [1:0]  sp_addr_o;
  logic [1:0]  sp_target_o;
  logic [63:0] sp_data_o;
  logic        busy_o;
  logic        done_o;

  typedef struct packed {
    logic [1:0]  addr;
    logic [1:0]  tgt;
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic mon_en = 1'b0;

  always #5 clk_i = ~clk_i;

  sp_writer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .target_i     (target_i),
    .n_rows_i     (n_rows_i),
    .n_cols_i     (n_cols_i),
    .elem_valid_i (elem_valid_i),
    .elem_data_i  (elem_data_i),
    .elem_ready_o (elem_ready_o),
    .sp_we_o      (sp_we_o),
    .sp_addr_o    (sp_addr_o),
    .sp_target_o  (sp_target_o),
    .sp_data_o    (sp_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every write must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (mon_en) begin
      if (sp_we_o === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", {62'd0, sp_addr_o}, 64'hFFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_addr",   {62'd0, sp_addr_o},   {62'd0, e.addr});
          chk("wr_target", {62'd0, sp_target_o}, {62'd0, e.tgt});
          chk("wr_data",   sp_data_o,            e.data);
          chk("wr_done",   {63'd0, done_o},      {63'd0, e.last});
        end
      end else begin
        chk("done_without_write", {63'd0, done_o}, 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic start(input logic [1:0] tgt, input logic [1:0] nr, input logic [1:0] nc);
    start_i  = 1'b1;
    target_i = tgt;
    n_rows_i = nr;
    n_cols_i = nc;
    tick();
    start_i  = 1'b0;
    target_i = 2'd0;
    n_rows_i = 2'd0;
    n_cols_i = 2'd0;
  endtask

  // Offer one element; the bench knows the writer is in WRITE, so it is taken this edge.
  task automatic send(input logic [63:0] d, input logic [1:0] addr, input logic [1:0] tgt,
                      input logic last);
    exp_t e;
    chk("elem_ready", {63'd0, elem_ready_o}, 64'd1);
    e.addr = addr;
    e.tgt  = tgt;
    e.data = d;
    e.last = last;
    sb.push_back(e);
    elem_valid_i = 1'b1;
    elem_data_i  = d;
    tick();
    elem_valid_i = 1'b0;
  endtask

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    target_i     = 2'd0;
    n_rows_i     = 2'd0;
    n_cols_i     = 2'd0;
    elem_valid_i = 1'b0;
    elem_data_i  = 64'd0;
    repeat (3) tick();
    chk("rst_we",    {63'd0, sp_we_o},      64'd0);
    chk("rst_busy",  {63'd0, busy_o},       64'd0);
    chk("rst_ready", {63'd0, elem_ready_o}, 64'd0);
    chk("rst_done",  {63'd0, done_o},       64'd0);
    chk("rst_addr",  {62'd0, sp_addr_o},    64'd0);
    chk("rst_tgt",   {62'd0, sp_target_o},  64'd0);
    chk("rst_data",  sp_data_o,             64'd0);
    rst_i  = 1'b0;
    mon_en = 1'b1;
    tick();

    // Full 2x2 via zero-encoded dims, back-to-back elements.
    start(2'd2, 2'd0, 2'd0);
    chk("t1_busy", {63'd0, busy_o}, 64'd1);
    send(64'hA, 2'd0, 2'd2, 1'b0);
    send(64'hB, 2'd1, 2'd2, 1'b0);
    send(64'hC, 2'd2, 2'd2, 1'b0);
    send(64'hD, 2'd3, 2'd2, 1'b1);
    chk("t1_busy_after", {63'd0, busy_o}, 64'd0);
    chk("t1_ready_after", {63'd0, elem_ready_o}, 64'd0);
    tick();

    // 1x2 with a stall cycle between the two elements.
    start(2'd1, 2'd1, 2'd2);
    send(64'h5, 2'd0, 2'd1, 1'b0);
    tick();
    chk("t2_busy_in_stall", {63'd0, busy_o}, 64'd1);
    send(64'h6, 2'd1, 2'd1, 1'b1);
    chk("t2_busy_after", {63'd0, busy_o}, 64'd0);
    tick();

    // 2x1: column wraps immediately, addresses 0 then 2.
    start(2'd0, 2'd2, 2'd1);
    send(64'h21, 2'd0, 2'd0, 1'b0);
    send(64'h22, 2'd2, 2'd0, 1'b1);
    tick();

    // Start during WRITE ignored; start on the done cycle accepted.
    start(2'd1, 2'd0, 2'd0);
    send(64'h31, 2'd0, 2'd1, 1'b0);
    start_i  = 1'b1;
    target_i = 2'd3;
    n_rows_i = 2'd1;
    n_cols_i = 2'd1;
    send(64'h32, 2'd1, 2'd1, 1'b0);
    start_i  = 1'b0;
    send(64'h33, 2'd2, 2'd1, 1'b0);
    send(64'h34, 2'd3, 2'd1, 1'b1);
    chk("t4_done_now", {63'd0, done_o}, 64'd1);
    start(2'd3, 2'd1, 2'd1);
    chk("t4_restart_busy", {63'd0, busy_o}, 64'd1);
    send(64'h77, 2'd0, 2'd3, 1'b1);
    chk("t4_busy_after", {63'd0, busy_o}, 64'd0);
    tick();

    // Reset after two of four elements; start and valid asserted during reset.
    start(2'd2, 2'd0, 2'd0);
    send(64'h41, 2'd0, 2'd2, 1'b0);
    send(64'h42, 2'd1, 2'd2, 1'b0);
    rst_i        = 1'b1;
    start_i      = 1'b1;
    target_i     = 2'd3;
    elem_valid_i = 1'b1;
    elem_data_i  = 64'h43;
    tick();
    chk("t5_we",    {63'd0, sp_we_o},      64'd0);
    chk("t5_ready", {63'd0, elem_ready_o}, 64'd0);
    chk("t5_busy",  {63'd0, busy_o},       64'd0);
    chk("t5_addr",  {62'd0, sp_addr_o},    64'd0);
    chk("t5_data",  sp_data_o,             64'd0);
    rst_i        = 1'b0;
    start_i      = 1'b0;
    target_i     = 2'd0;
    elem_valid_i = 1'b0;
    tick();
    chk("t5_idle_after", {63'd0, busy_o}, 64'd0);
    start(2'd0, 2'd0, 2'd0);
    send(64'h51, 2'd0, 2'd0, 1'b0);
    send(64'h52, 2'd1, 2'd0, 1'b0);
    send(64'h53, 2'd2, 2'd0, 1'b0);
    send(64'h54, 2'd3, 2'd0, 1'b1);
    tick();

    // Oversized dims 3x3 clamp to 2x2.
    start(2'd1, 2'd3, 2'd3);
    send(64'h61, 2'd0, 2'd1, 1'b0);
    send(64'h62, 2'd1, 2'd1, 1'b0);
    send(64'h63, 2'd2, 2'd1, 1'b0);
    chk("t6_busy_before_last", {63'd0, busy_o}, 64'd1);
    send(64'h64, 2'd3, 2'd1, 1'b1);
    chk("t6_busy_after", {63'd0, busy_o}, 64'd0);

    repeat (3) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sp_writer.md
SP_WRITER -- requirements
Module: sp_writer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter SP_NTARGETS, default 4, SHALL set the number of scratchpad targets.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL set the operand element width.
REQ-004 Parameter BUS_WIDTH, default 64, SHALL set the result element and scratchpad word width.
REQ-005 Local MAX_DIM SHALL equal BUS_WIDTH/DATA_WIDTH; AW = 2*clog2(MAX_DIM); TW = clog2(SP_NTARGETS); DW = clog2(MAX_DIM)+1.
REQ-006 The ports SHALL be:
- clk_i  in  1  clock
- rst_i  in  1  sync reset, active-high
- start_i  in  1  begin a matrix write
- target_i  in  TW  destination target, latched at start
- n_rows_i  in  DW  rows, 1..MAX_DIM, 0 means MAX_DIM, latched at start
- n_cols_i  in  DW  cols, same encoding, latched at start
- elem_valid_i  in  1  result element valid
- elem_data_i  in  BUS_WIDTH  result element, row-major order
- elem_ready_o  out  1  writer accepts element
- sp_we_o  out  1  scratchpad write enable
- sp_addr_o  out  AW  scratchpad sub-address
- sp_target_o  out  TW  scratchpad write target
- sp_data_o  out  BUS_WIDTH  scratchpad write data
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse

Function
REQ-007 FSM states SHALL be IDLE and WRITE only.
REQ-008 IDLE: start_i=1 SHALL latch target, n_rows, n_cols, clear row/col counters, and move to WRITE next cycle; other inputs ignored.
REQ-009 elem_ready_o SHALL equal (state==WRITE); busy_o SHALL equal (state==WRITE).
REQ-010 Handshake: an element SHALL transfer in any cycle with elem_valid_i & elem_ready_o; elem_valid_i low SHALL stall without side effects.
REQ-011 Each transfer SHALL produce, in the next cycle only, sp_we_o=1, sp_addr_o=row*MAX_DIM+col, sp_target_o=latched target, sp_data_o=elem_data_i (latency 1, all registered).
REQ-012 sp_we_o SHALL be 0 in every cycle not following a transfer; sp_addr_o/sp_data_o/sp_target_o SHALL hold their last values when sp_we_o=0.
REQ-013 After each transfer col SHALL increment; at col==n_cols-1 col SHALL wrap to 0 and row SHALL increment.
REQ-014 Transfer at row==n_rows-1, col==n_cols-1 SHALL return state to IDLE next cycle and pulse done_o for exactly that cycle, coincident with the final sp_we_o.
REQ-015 start_i while in WRITE SHALL be ignored; target/dimensions SHALL not change mid-transfer.
REQ-016 start_i in the cycle done_o is high SHALL be accepted (state is IDLE); final write still completes with the old target.
REQ-017 n_rows_i or n_cols_i > MAX_DIM SHALL be clamped to MAX_DIM at latch.
REQ-018 Unwritten addresses (col>=n_cols or row>=n_rows) SHALL never be driven with sp_we_o=1.
REQ-019 Counters SHALL be wide enough to hold MAX_DIM-1 without overflow; address arithmetic SHALL be unsigned, AW bits.

Reset
REQ-020 rst_i=1 at a clock edge SHALL force IDLE, counters 0, sp_we_o=0, done_o=0, busy_o=0, elem_ready_o=0, sp_addr_o=0, sp_target_o=0, sp_data_o=0.
REQ-021 rst_i mid-transfer SHALL abort with no further sp_we_o and no done_o; reset SHALL take priority over start_i and handshakes.

Verification
REQ-022 Defaults, start target=2, dims 0/0, four elements 0xA,0xB,0xC,0xD back-to-back -> writes addr 0,1,2,3 target 2 on consecutive cycles, done_o with addr 3, busy_o low after.
REQ-023 Dims 1x2, target 1, elem_valid_i toggled 1,0,1 -> exactly two writes addr 0 then 1, no write in stall cycle, done_o once.
REQ-024 Dims 2x1 -> writes addr 0 then 2 (col wrap); addresses 1 and 3 never written.
REQ-025 start_i reasserted with target=3 during WRITE -> ignored, all writes target original; start_i on done_o cycle -> second transfer begins next cycle.
REQ-026 rst_i after second of four elements -> sp_we_o=0 from next cycle, no done_o, elem_ready_o=0, next start behaves as fresh.
REQ-027 n_rows_i=n_cols_i=3 -> clamped to 2, four writes, done_o after fourth.
